// File: rtl/armleocpu_burst_sram_if.sv
// Burst SRAM slave bus: one command/beat channel plus a read-data return channel.
// Latency: none, this is a bundle of wires.
// Backpressure: slave drives s_waitrequest; the master holds its command/beat while it is high.
//
// Signals:
//   s_address       byte address (bits [1:0] unused by the slave)
//   s_burstcount    beats per burst, 0 encodes 16
//   s_read/s_write  command (and, for writes, beat) request
//   s_writedata     write beat data
//   s_byteenable    per-byte write lane enable
//   s_waitrequest   command/beat not accepted this cycle
//   s_readdata      read beat data
//   s_readdatavalid s_readdata carries a beat this cycle
interface armleocpu_burst_sram_if;
   logic [33:0] s_address;
   logic [3:0]  s_burstcount;
   logic        s_read;
   logic        s_write;
   logic [31:0] s_writedata;
   logic [3:0]  s_byteenable;
   logic        s_waitrequest;
   logic [31:0] s_readdata;
   logic        s_readdatavalid;

   modport master (
      output s_address, s_burstcount, s_read, s_write, s_writedata, s_byteenable,
      input  s_waitrequest, s_readdata, s_readdatavalid
   );

   modport slave (
      input  s_address, s_burstcount, s_read, s_write, s_writedata, s_byteenable,
      output s_waitrequest, s_readdata, s_readdatavalid
   );
endinterface

// File: rtl/armleocpu_burst_sram.sv
// Burst-capable single-port SRAM, 2^DEPTH_W x 32 bits, with byte-enabled writes.
// Latency: first read beat one cycle after command acceptance, then one beat per cycle.
// Backpressure: s_waitrequest high during read bursts; write beats may be stalled by the master.
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst_n  asynchronous active-low reset (memory contents are not cleared)
//   s      armleocpu_burst_sram_if slave modport (command, write data, read data)
//
// Optional feature: define ARMLEOCPU_BURST_SRAM_WAITSTATE_EN to insert one wait
// state before every command acceptance and every write beat.
module armleocpu_burst_sram #(
   parameter int DEPTH_W = 10
) (
   input  logic                     clk,
   input  logic                     rst_n,
   armleocpu_burst_sram_if.slave    s
);

`ifdef ARMLEOCPU_BURST_SRAM_WAITSTATE_EN
   // Idle and between write beats the slave parks with waitrequest high and
   // drops it for exactly one cycle once a request is seen.
   localparam logic WAIT_IDLE = 1'b1;
   localparam logic WAIT_BEAT = 1'b1;
`else
   localparam logic WAIT_IDLE = 1'b0;
   localparam logic WAIT_BEAT = 1'b0;
`endif

   localparam int WORDS = 1 << DEPTH_W;
   localparam logic [DEPTH_W-1:0] IDX_ONE = {{(DEPTH_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE
   } state_t;

   state_t              state;
   logic [DEPTH_W-1:0]  ptr;          // word index of the next beat
   logic [4:0]          beats_left;   // beats still to transfer after the current one
   logic                waitrequest_r;
   logic                readdatavalid_r;
   logic [31:0]         readdata_r;

   logic [31:0]         mem [0:WORDS-1];

   logic [DEPTH_W-1:0]  cmd_idx;
   logic [4:0]          cmd_beats;
   logic                rd_cmd;
   logic                wr_cmd;
   logic                idle_accept;
   logic                wr_beat;
   logic                mem_we;
   logic [DEPTH_W-1:0]  mem_idx;
   logic                unused_addr;

   assign s.s_waitrequest   = waitrequest_r;
   assign s.s_readdatavalid = readdatavalid_r;
   assign s.s_readdata      = readdata_r;

   // Address bits outside the word index are don't-care (memory aliases).
   assign unused_addr = ^{s.s_address[33:DEPTH_W+2], s.s_address[1:0]};

   assign cmd_idx   = s.s_address[DEPTH_W+1:2];
   assign cmd_beats = (s.s_burstcount == 4'd0) ? 5'd16 : {1'b0, s.s_burstcount};

   // Read and write together is not a command; it is ignored entirely.
   assign rd_cmd = s.s_read & ~s.s_write;
   assign wr_cmd = s.s_write & ~s.s_read;

   assign idle_accept = (state == IDLE) && !waitrequest_r;
   assign wr_beat     = (state == WRITE) && s.s_write && !waitrequest_r;

   // The first write beat travels with the command; later beats use the
   // running pointer. Gating with rst_n keeps reset from letting a beat slip in.
   assign mem_we  = rst_n && ((idle_accept && wr_cmd) || wr_beat);
   assign mem_idx = (state == WRITE) ? ptr : cmd_idx;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (s.s_byteenable[b]) begin
               mem[mem_idx][8*b +: 8] <= s.s_writedata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         ptr             <= '0;
         beats_left      <= 5'd0;
         waitrequest_r   <= WAIT_IDLE;
         readdatavalid_r <= 1'b0;
         readdata_r      <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               readdatavalid_r <= 1'b0;
               if (rd_cmd || wr_cmd) begin
                  if (waitrequest_r) begin
                     // Wait-state cycle: accept on the next cycle.
                     waitrequest_r <= 1'b0;
                  end else begin
                     ptr        <= cmd_idx + IDX_ONE;
                     beats_left <= cmd_beats - 5'd1;
                     if (rd_cmd) begin
                        // First beat is fetched at acceptance so it appears
                        // on the very next cycle.
                        readdata_r      <= mem[cmd_idx];
                        readdatavalid_r <= 1'b1;
                        waitrequest_r   <= 1'b1;
                        state           <= READ;
                     end else if (cmd_beats == 5'd1) begin
                        waitrequest_r <= WAIT_IDLE;
                     end else begin
                        waitrequest_r <= WAIT_BEAT;
                        state         <= WRITE;
                     end
                  end
               end else begin
                  waitrequest_r <= WAIT_IDLE;
               end
            end

            READ: begin
               if (beats_left != 5'd0) begin
                  readdata_r      <= mem[ptr];
                  readdatavalid_r <= 1'b1;
                  ptr             <= ptr + IDX_ONE;
                  beats_left      <= beats_left - 5'd1;
               end else begin
                  // The last beat is on the bus this cycle; done after it.
                  readdatavalid_r <= 1'b0;
                  waitrequest_r   <= WAIT_IDLE;
                  state           <= IDLE;
               end
            end

            WRITE: begin
               readdatavalid_r <= 1'b0;
               if (s.s_write) begin
                  if (waitrequest_r) begin
                     waitrequest_r <= 1'b0;
                  end else begin
                     ptr        <= ptr + IDX_ONE;
                     beats_left <= beats_left - 5'd1;
                     if (beats_left == 5'd1) begin
                        waitrequest_r <= WAIT_IDLE;
                        state         <= IDLE;
                     end else begin
                        waitrequest_r <= WAIT_BEAT;
                     end
                  end
               end
            end

            default: begin
               readdatavalid_r <= 1'b0;
               waitrequest_r   <= WAIT_IDLE;
               state           <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_armleocpu_burst_sram.sv
// Directed bench for armleocpu_burst_sram with a read-data scoreboard.
// Latency: checks first read beat one cycle after acceptance and gap-free bursts.
// Backpressure: honours s_waitrequest before every command and write beat.
module tb_armleocpu_burst_sram;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   armleocpu_burst_sram_if bus ();

   armleocpu_burst_sram #(.DEPTH_W(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s     (bus)
   );

`ifdef ARMLEOCPU_BURST_SRAM_WAITSTATE_EN
   localparam logic WAIT_IDLE_EXP = 1'b1;
`else
   localparam logic WAIT_IDLE_EXP = 1'b0;
`endif

   int          checks = 0;
   int          errors = 0;
   int          stray  = 0;
   bit          rd_window = 1'b0;
   logic [31:0] model [0:1023];
   logic [31:0] expq [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   // Any valid beat outside a window where the bench expects read data.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.s_readdatavalid === 1'b1 && !rd_window) stray++;
   end

   // Present a command/beat right after a rising edge and hold it until taken.
   task automatic issue(input logic rd, input logic wr, input logic [33:0] addr,
                        input logic [3:0] bc, input logic [31:0] wd, input logic [3:0] be,
                        output bit ok);
      bus.s_read       = rd;
      bus.s_write      = wr;
      bus.s_address    = addr;
      bus.s_burstcount = bc;
      bus.s_writedata  = wd;
      bus.s_byteenable = be;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.s_waitrequest === 1'b0) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      bus.s_read  = 1'b0;
      bus.s_write = 1'b0;
      chk("accept", ok, 1'b1);
   endtask

   task automatic write_burst(input logic [33:0] addr, input logic [3:0] bc,
                              input logic [31:0] base, input logic [3:0] be,
                              input int stall_at);
      int          n;
      bit          ok;
      logic [9:0]  idx;
      n   = (bc == 4'd0) ? 16 : int'(bc);
      idx = addr[11:2];
      for (int k = 0; k < n; k++) begin
         if (k == stall_at) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
         end
         issue(1'b0, 1'b1, addr, bc, base + k, be, ok);
         if (ok) model[idx] = merge(model[idx], base + k, be);
         idx = idx + 10'd1;
      end
   endtask

   // Collect 'take' beats; a full burst also checks valid drops afterwards.
   task automatic read_burst(input logic [33:0] addr, input logic [3:0] bc,
                             input int take, input bit use_model);
      int          n;
      bit          ok;
      logic [9:0]  idx;
      logic [31:0] e;
      n   = (bc == 4'd0) ? 16 : int'(bc);
      idx = addr[11:2];
      if (use_model) for (int k = 0; k < n; k++) expq.push_back(model[idx + 10'(k)]);
      issue(1'b1, 1'b0, addr, bc, 32'd0, 4'd0, ok);
      if (!ok) begin
         expq.delete();
         return;
      end
      rd_window = 1'b1;
      for (int k = 0; k < take; k++) begin
         @(negedge clk);
         chk("rd_valid", bus.s_readdatavalid, 1'b1);
         chk("rd_wait", bus.s_waitrequest, 1'b1);
         e = (expq.size() != 0) ? expq.pop_front() : 32'hxxxx_xxxx;
         chk("rd_data", bus.s_readdata, e);
      end
      if (take >= n) begin
         @(posedge clk); #1;
         rd_window = 1'b0;
         @(negedge clk);
         chk("rd_valid_end", bus.s_readdatavalid, 1'b0);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      bit ok;
      for (int i = 0; i < 1024; i++) model[i] = 32'd0;
      rst_n            = 1'b0;
      bus.s_address    = '0;
      bus.s_burstcount = 4'd0;
      bus.s_read       = 1'b0;
      bus.s_write      = 1'b0;
      bus.s_writedata  = 32'd0;
      bus.s_byteenable = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", bus.s_readdatavalid, 1'b0);
      chk("rst_data", bus.s_readdata, 32'd0);
      chk("rst_wait", bus.s_waitrequest, WAIT_IDLE_EXP);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single write then single read.
      write_burst(34'h40, 4'd1, 32'hDEADBEEF, 4'hF, -1);
      expq.push_back(32'hDEADBEEF);
      read_burst(34'h40, 4'd1, 1, 1'b0);

      // 16-beat write with a stall mid-burst, then 16-beat read.
      write_burst(34'h100, 4'd0, 32'd0, 4'hF, 7);
      for (int k = 0; k < 16; k++) expq.push_back(32'(k));
      read_burst(34'h100, 4'd0, 16, 1'b0);

      // Partial byte-enable write.
      write_burst(34'h200, 4'd1, 32'h11223344, 4'hF, -1);
      write_burst(34'h200, 4'd1, 32'hAABBCCDD, 4'b0101, -1);
      expq.push_back(32'h11BB33DD);
      read_burst(34'h200, 4'd1, 1, 1'b0);

      // Burst wrapping past the top of memory, both directions.
      write_burst(34'hFF8, 4'd4, 32'hC0DE0000, 4'hF, 2);
      for (int k = 0; k < 4; k++) expq.push_back(32'hC0DE0000 + k);
      read_burst(34'hFF8, 4'd4, 4, 1'b0);
      expq.push_back(32'hC0DE0001);
      read_burst(34'h2_0000_0FFC, 4'd1, 1, 1'b0);

      // Read and write together are ignored.
      bus.s_read       = 1'b1;
      bus.s_write      = 1'b1;
      bus.s_address    = 34'h40;
      bus.s_burstcount = 4'd1;
      bus.s_writedata  = 32'h0BAD0BAD;
      bus.s_byteenable = 4'hF;
      repeat (2) @(negedge clk);
      chk("both_wait", bus.s_waitrequest, WAIT_IDLE_EXP);
      @(posedge clk); #1;
      bus.s_read  = 1'b0;
      bus.s_write = 1'b0;
      expq.push_back(32'hDEADBEEF);
      read_burst(34'h40, 4'd1, 1, 1'b0);

      // Empty byte-enable consumes the beat but leaves memory alone.
      write_burst(34'h40, 4'd1, 32'h12345678, 4'h0, -1);
      expq.push_back(32'hDEADBEEF);
      read_burst(34'h40, 4'd1, 1, 1'b0);

`ifdef ARMLEOCPU_BURST_SRAM_WAITSTATE_EN
      // One wait cycle before a single write is taken.
      bus.s_write      = 1'b1;
      bus.s_address    = 34'h300;
      bus.s_burstcount = 4'd1;
      bus.s_writedata  = 32'h5A5A5A5A;
      bus.s_byteenable = 4'hF;
      @(negedge clk);
      chk("ws_wait_hi", bus.s_waitrequest, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("ws_wait_lo", bus.s_waitrequest, 1'b0);
      @(posedge clk); #1;
      bus.s_write = 1'b0;
      model[10'h0C0] = 32'h5A5A5A5A;
      expq.push_back(32'h5A5A5A5A);
      read_burst(34'h300, 4'd1, 1, 1'b0);
`endif

      // Reset in the middle of a 16-beat read.
      for (int k = 0; k < 16; k++) expq.push_back(32'(k));
      read_burst(34'h100, 4'd0, 3, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_valid", bus.s_readdatavalid, 1'b0);
      chk("abort_data", bus.s_readdata, 32'd0);
      chk("abort_wait", bus.s_waitrequest, WAIT_IDLE_EXP);
      expq.delete();
      rd_window = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      expq.push_back(32'hDEADBEEF);
      read_burst(34'h40, 4'd1, 1, 1'b0);
      expq.push_back(32'd1);
      read_burst(34'h104, 4'd1, 1, 1'b0);

      repeat (3) @(posedge clk);
      chk("stray_valid", 32'(stray), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
